// File: rtl/aes128_package.sv
// Shared types for the masked AES datapath: byte type, collector FSM states
// and the collector's slot-counter width helper.
package aes128_package;

  typedef logic [7:0] bv8_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } unmask_state_t;

  function automatic int unmask_counter_width(input int num_bytes);
    return $clog2(num_bytes);
  endfunction

endpackage

// File: rtl/masked_unmask_bv.sv
// Combinational recombination of NUM_SHARES Boolean shares into one byte.
// Callers must feed it from a register so shares never meet on a raw path.
module masked_unmask_bv
  import aes128_package::*;
#(
  parameter int NUM_SHARES = 2
) (
  input  bv8_t [NUM_SHARES-1:0] shares_i,
  output bv8_t                  byte_o
);

  always_comb begin
    byte_o = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      byte_o = byte_o ^ shares_i[i];
    end
  end

endmodule

// File: rtl/masked_bv8_unmask_collector.sv
// Registers incoming shares, unmasks them and packs NUM_BYTES bytes into a block.
// Optional synchronous flush input is enabled by defining UNMASK_FLUSH_EN.
module masked_bv8_unmask_collector
  import aes128_package::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int NUM_BYTES  = 16
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  input  bv8_t [NUM_SHARES-1:0]    in_shares,
  input  logic                     in_valid,
  output logic                     out_ready,
  output logic [8*NUM_BYTES-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     in_ready,
`ifdef UNMASK_FLUSH_EN
  input  logic                     in_flush,
`endif
  output unmask_state_t            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and out_ready depends only on
  // registered state.

  localparam int CW = unmask_counter_width(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  unmask_state_t                state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         s1_valid_q, s1_valid_d;
  bv8_t [NUM_SHARES-1:0]        s1_shares_q, s1_shares_d;
  logic [8*NUM_BYTES-1:0]       data_q, data_d;

  logic flush;
  logic accept;
  bv8_t byte_s2;

`ifdef UNMASK_FLUSH_EN
  assign flush = in_flush;
`else
  assign flush = 1'b0;
`endif

  masked_unmask_bv #(
    .NUM_SHARES(NUM_SHARES)
  ) u_unmask (
    .shares_i(s1_shares_q),
    .byte_o  (byte_s2)
  );

  assign out_ready   = !s1_valid_q || (state_q == COLLECT);
  assign out_valid   = (state_q == HOLD);
  assign out_data    = data_q;
  assign dbg_state_o = state_q;
  assign accept      = in_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_shares_d = s1_shares_q;
    data_d      = data_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      cnt_d      = '0;
      state_d    = COLLECT;
    end else begin
      if (accept) begin
        s1_shares_d = in_shares;
        s1_valid_d  = 1'b1;
      end
      case (state_q)
        COLLECT: begin
          if (s1_valid_q) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
              if (cnt_q == CW'(k)) data_d[8*k +: 8] = byte_s2;
            end
            if (!accept) s1_valid_d = 1'b0;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        // The held s1 byte waits for the cycle after the handshake.
        HOLD: begin
          if (in_ready) state_d = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_shares_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_shares_q <= s1_shares_d;
      data_q      <= data_d;
    end
  end

endmodule
